// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the sequential shift-and-add multiplier.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on the operand side and out_valid/out_ready on the result side.
//
// Ports (as seen by the multiplier through the slave modport):
//   in_valid, signed_mode, A[M-1:0], B[N-1:0]  operand request (in)
//   in_ready                                   operand accept (out)
//   out_valid, C[M+N-1:0]                      product (out)
//   out_ready                                  product accept (in)
interface seq_shift_add_multiplier_if #(
    parameter int M = 8,
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             signed_mode;
    logic [M-1:0]     A;
    logic [N-1:0]     B;
    logic             out_valid;
    logic             out_ready;
    logic [M+N-1:0]   C;

    // Requester side: drives operands and consumes the product.
    modport master (
        output in_valid, signed_mode, A, B, out_ready,
        input  in_ready, out_valid, C
    );

    // Multiplier side.
    modport slave (
        input  in_valid, signed_mode, A, B, out_ready,
        output in_ready, out_valid, C
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier, one multiplier bit per clock, unsigned or two's complement per operation.
// Latency: accept cycle is 0, product valid from cycle N+1; one product every N+2 cycles at full rate.
// Backpressure: in_ready only in IDLE; product and out_valid are held in DONE until out_ready.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any operation in flight
//   bus   seq_shift_add_multiplier_if slave: in_valid/in_ready/signed_mode/A/B,
//         out_valid/out_ready/C
module seq_shift_add_multiplier #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    seq_shift_add_multiplier_if.slave    bus
);
    // One guard bit above the product so the accumulator can never wrap.
    localparam int W  = M + N + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]   acc;
    logic [W-1:0]   mcand;      // |A| shifted left by the current bit index
    logic [N:0]     mplier;     // |B| shifted right; bit 0 is the current multiplier bit
    logic [KW-1:0]  k;
    logic           neg;

    logic           last_step;
    logic [M:0]     a_ext;
    logic [N:0]     b_ext;
    logic [M:0]     mag_a;
    logic [N:0]     mag_b;
    logic [W-1:0]   sum;
    logic           sum_msb_unused;

    // Sign-extend by one bit only in signed mode, then take the magnitude in the
    // wider width so the most negative operand still has a representable magnitude.
    assign a_ext = {bus.signed_mode & bus.A[M-1], bus.A};
    assign b_ext = {bus.signed_mode & bus.B[N-1], bus.B};
    assign mag_a = a_ext[M] ? -a_ext : a_ext;
    assign mag_b = b_ext[N] ? -b_ext : b_ext;

    assign last_step = (k == KW'(N - 1));
    assign sum       = acc + (mplier[0] ? mcand : '0);

    // The magnitude product always fits in M+N bits; the guard bit is never set.
    assign sum_msb_unused = sum[W-1];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)  state_d = RUN;
            RUN:  if (last_step)     state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            k      <= '0;
            neg    <= 1'b0;
            bus.C  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= '0;
                        mcand  <= {{(W-M-1){1'b0}}, mag_a};
                        mplier <= mag_b;
                        k      <= '0;
                        neg    <= a_ext[M] ^ b_ext[N];
                    end
                end
                RUN: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    k      <= k + KW'(1);
                    // Fold the final add straight into C so out_valid follows the last bit.
                    if (last_step) begin
                        bus.C <= neg ? -sum[M+N-1:0] : sum[M+N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
